// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcode and funct7 constants for the issue/ALU boundary.
package alu_pkg;

  localparam int CTL_W = 4;

  localparam logic [CTL_W-1:0] CTL_AND  = 4'b0000;
  localparam logic [CTL_W-1:0] CTL_OR   = 4'b0001;
  localparam logic [CTL_W-1:0] CTL_ADD  = 4'b0010;
  localparam logic [CTL_W-1:0] CTL_XOR  = 4'b0011;
  localparam logic [CTL_W-1:0] CTL_SLL  = 4'b0100;
  localparam logic [CTL_W-1:0] CTL_SRL  = 4'b0101;
  localparam logic [CTL_W-1:0] CTL_SUB  = 4'b0110;
  localparam logic [CTL_W-1:0] CTL_SLT  = 4'b0111;
  localparam logic [CTL_W-1:0] CTL_SLTU = 4'b1000;
  localparam logic [CTL_W-1:0] CTL_SRA  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational opcode/funct3/funct7 -> ALU control, operand-B select and illegal flag.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             use_imm,
  output logic             illegal
);

  logic [CTL_W-1:0] ctl;

  always_comb begin
    ctl     = CTL_AND;
    use_imm = 1'b0;
    illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  ctl = CTL_ADD;
            3'b001:  ctl = CTL_SLL;
            3'b010:  ctl = CTL_SLT;
            3'b011:  ctl = CTL_SLTU;
            3'b100:  ctl = CTL_XOR;
            3'b101:  ctl = CTL_SRL;
            3'b110:  ctl = CTL_OR;
            default: ctl = CTL_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) ctl = CTL_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) ctl = CTL_SRA;
        else illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        // funct7 field is immediate bits here, so only shifts inspect it (bit 0 is shamt[5])
        case (funct3)
          3'b000: ctl = CTL_ADD;
          3'b001: if (funct7[6:1] == 6'b000000) ctl = CTL_SLL; else illegal = 1'b1;
          3'b010: ctl = CTL_SLT;
          3'b011: ctl = CTL_SLTU;
          3'b100: ctl = CTL_XOR;
          3'b101: begin
            if (funct7[6:1] == 6'b000000)      ctl = CTL_SRL;
            else if (funct7[6:1] == 6'b010000) ctl = CTL_SRA;
            else                               illegal = 1'b1;
          end
          3'b110:  ctl = CTL_OR;
          default: ctl = CTL_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        use_imm = 1'b1;
        ctl     = CTL_ADD;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: ctl = CTL_SUB;
          3'b100, 3'b101: ctl = CTL_SLT;
          3'b110, 3'b111: ctl = CTL_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_ctl = illegal ? CTL_AND : ctl;

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage: decodes ALU ops and registers them behind a 2-entry (output + skid) buffer.
// Optional ALU_DISPATCH_PERF_EN adds issue_cnt/stall_cnt counters.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTL_W-1:0] alu_ctl,
  output logic [XLEN-1:0]  op_a,
  output logic [XLEN-1:0]  op_b,
  output logic             illegal
`ifdef ALU_DISPATCH_PERF_EN
  ,
  output logic [31:0]      issue_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  typedef struct packed {
    logic [CTL_W-1:0] ctl;
    logic             ill;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } beat_t;

  logic [CTL_W-1:0] dec_ctl;
  logic             dec_use_imm;
  logic             dec_illegal;

  alu_ctl_decode u_dec (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_ctl (dec_ctl),
    .use_imm (dec_use_imm),
    .illegal (dec_illegal)
  );

  beat_t in_beat, out_q, skid_q;
  logic  skid_full;
  logic  acc, drain;

  assign in_beat = '{ctl: dec_ctl, ill: dec_illegal, a: rs1_data,
                     b: dec_use_imm ? imm : rs2_data};
  assign acc     = in_valid & in_ready;
  assign drain   = out_valid & out_ready;

  // in_ready comes straight from a flop, keeping the upstream path registered
  assign in_ready = ~skid_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (!out_valid || drain) begin
      if (skid_full) begin
        out_q     <= skid_q;
        skid_full <= 1'b0;
      end else begin
        out_valid <= acc;
        if (acc) out_q <= in_beat;
      end
    end else if (acc) begin
      skid_q    <= in_beat;
      skid_full <= 1'b1;
    end
  end

  assign alu_ctl = out_q.ctl;
  assign illegal = out_q.ill;
  assign op_a    = out_q.a;
  assign op_b    = out_q.b;

`ifdef ALU_DISPATCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (drain)                   issue_cnt <= issue_cnt + 32'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: decode table, latency, back-pressure, streaming, reset.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [63:0] rs1_data, rs2_data, imm;
  logic        out_valid, out_ready;
  logic [3:0]  alu_ctl;
  logic [63:0] op_a, op_b;
  logic        illegal;
`ifdef ALU_DISPATCH_PERF_EN
  logic [31:0] issue_cnt, stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctl(alu_ctl),
    .op_a(op_a), .op_b(op_b), .illegal(illegal)
`ifdef ALU_DISPATCH_PERF_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add(input logic [63:0] a);
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
    rs1_data = a; rs2_data = 64'h1; imm = 64'h2;
  endtask

  // decode vectors: opcode, funct3, funct7, expected ctl, illegal, op_b from imm
  localparam int NV = 14;
  logic [6:0] v_opc [NV] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
                             7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011,
                             7'b1100011, 7'b0100011, 7'b0010011, 7'b0110011,
                             7'b0110011, 7'b1100011};
  logic [2:0] v_f3  [NV] = '{3'b000, 3'b101, 3'b110, 3'b000, 3'b100, 3'b001, 3'b001,
                             3'b000, 3'b010, 3'b011, 3'b101, 3'b011, 3'b101, 3'b101};
  logic [6:0] v_f7  [NV] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h01,
                             7'h20, 7'h00, 7'h00, 7'h21, 7'h00, 7'h00, 7'h00};
  logic [3:0] v_ctl [NV] = '{4'b0110, 4'b1001, 4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0100,
                             4'b0010, 4'b0000, 4'b0010, 4'b1001, 4'b1000, 4'b0101, 4'b0111};
  logic       v_ill [NV] = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  logic       v_imm [NV] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0};

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    set_add(64'hDEAD);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_ctl", alu_ctl, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("idle_out_valid", out_valid, 0);

    // latency: LOAD rs1=5 imm=7
    out_ready = 1'b1;
    opcode = 7'b0000011; funct3 = 3'b011; funct7 = 7'h00;
    rs1_data = 64'd5; rs2_data = 64'd99; imm = 64'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_valid", out_valid, 1);
    chk("lat_op_a", op_a, 5);
    chk("lat_op_b", op_b, 7);
    chk("lat_ctl", alu_ctl, 4'b0010);
    step();
    chk("lat_drained", out_valid, 0);

    // decode sweep
    for (int i = 0; i < NV; i++) begin
      opcode = v_opc[i]; funct3 = v_f3[i]; funct7 = v_f7[i];
      rs1_data = 64'h3000 + 64'(i); rs2_data = 64'h1000 + 64'(i); imm = 64'h2000 + 64'(i);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("dec%0d_valid", i), out_valid, 1);
      chk($sformatf("dec%0d_ctl", i), alu_ctl, v_ctl[i]);
      chk($sformatf("dec%0d_ill", i), illegal, v_ill[i]);
      chk($sformatf("dec%0d_op_a", i), op_a, 64'h3000 + 64'(i));
      chk($sformatf("dec%0d_op_b", i), op_b, v_imm[i] ? 64'h2000 + 64'(i) : 64'h1000 + 64'(i));
    end
    step();

    // back-pressure: A, B, C with out_ready low
    out_ready = 1'b0; in_valid = 1'b1;
    set_add(64'hA); step();
    chk("bp_ready_after_a", in_ready, 1);
    set_add(64'hB); step();
    chk("bp_ready_full", in_ready, 0);
    chk("bp_head_a", op_a, 64'hA);
    set_add(64'hC);
    step(); step();
    chk("bp_still_full", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_a", op_a, 64'hA);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", op_a, 64'hB);
    chk("bp_ready_reopen", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_out_c", op_a, 64'hC);
    chk("bp_c_valid", out_valid, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // continuous streaming with out_ready high
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_add(64'h10 + 64'(i));
      step();
      chk($sformatf("str%0d_valid", i), out_valid, 1);
      chk($sformatf("str%0d_op_a", i), op_a, 64'h10 + 64'(i));
      chk($sformatf("str%0d_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("str_end", out_valid, 0);

    // reset while output and skid are both full
    out_ready = 1'b0; in_valid = 1'b1;
    set_add(64'hD); step();
    set_add(64'hE); step();
    in_valid = 1'b0;
    chk("mr_full", in_ready, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("mr_no_stale0", out_valid, 0);
    step();
    chk("mr_no_stale1", out_valid, 0);
`ifdef ALU_DISPATCH_PERF_EN
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("perf_rst_issue", issue_cnt, 0);
    chk("perf_rst_stall", stall_cnt, 0);
`endif

    // 4 stall cycles then 3 issues (F, G, H)
    out_ready = 1'b0; in_valid = 1'b1;
    set_add(64'hF); step();
    set_add(64'h6); step();
    in_valid = 1'b0;
    step(); step(); step();
    out_ready = 1'b1;
    step();
    chk("pf_out_g", op_a, 64'h6);
    in_valid = 1'b1; set_add(64'h8);
    step();
    in_valid = 1'b0;
    chk("pf_out_h", op_a, 64'h8);
    step();
    chk("pf_empty", out_valid, 0);
`ifdef ALU_DISPATCH_PERF_EN
    chk("perf_stall", stall_cnt, 4);
    chk("perf_issue", issue_cnt, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
